// File: rtl/lsu_mem_port.sv
// RV32I load/store unit: one request at a time into a unified memory with MEM_LATENCY read delay.
// Optional: define LSU_MISALIGN_CHECK_EN to report misaligned LH/LHU/SH/LW/SW as access errors.
module lsu_mem_port #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_rstrb_o,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_wdata_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic        is_store;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [3:0]  wmask;
  logic [1:0]  wait_cnt;
  logic        legal;
  logic        req_err;
  logic [3:0]  wmask_dec;
  logic [31:0] wdata_dec;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Request legality; misalignment only matters when the check is built in.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    legal   = 1'b0;
    req_err = 1'b0;
    if (req_we_i) legal = (req_funct3_i inside {3'b000, 3'b001, 3'b010});
    else          legal = (req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_CHECK_EN
    req_err = !legal ||
              (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
              (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
`else
    req_err = !legal;
`endif
  end

  always_comb begin
    wmask_dec = 4'b1111;
    wdata_dec = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        wmask_dec = 4'b0001 << req_addr_i[1:0];
        wdata_dec = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        wmask_dec = 4'b0011 << {req_addr_i[1], 1'b0};
        wdata_dec = {2{req_wdata_i[15:0]}};
      end
      default: begin
        wmask_dec = 4'b1111;
        wdata_dec = req_wdata_i;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returning word.
  always_comb begin
    case (addr_lo)
      2'b00:   byte_sel = mem_rdata_i[7:0];
      2'b01:   byte_sel = mem_rdata_i[15:8];
      2'b10:   byte_sel = mem_rdata_i[23:16];
      default: byte_sel = mem_rdata_i[31:24];
    endcase
    half_sel = addr_lo[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'b0, byte_sel};
      3'b101:  load_ext = {16'b0, half_sel};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid_i) state_next = req_err ? RESP : ISSUE;
      ISSUE:   state_next = is_store ? RESP : WAIT;
      WAIT:    if (wait_cnt == 2'd0) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state == IDLE);
    rsp_valid_o = (state == RESP);
    mem_rstrb_o = (state == ISSUE) && !is_store;
    mem_wmask_o = ((state == ISSUE) && is_store) ? wmask : 4'b0000;
  end

  // Request capture, wait countdown and response data; address/wdata hold between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store    <= 1'b0;
      funct3      <= 3'b000;
      addr_lo     <= 2'b00;
      wmask       <= 4'b0000;
      wait_cnt    <= 2'd0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid_i) begin
        is_store    <= req_we_i;
        funct3      <= req_funct3_i;
        addr_lo     <= req_addr_i[1:0];
        rsp_err_o   <= req_err;
        rsp_rdata_o <= '0;
        if (!req_err) begin
          mem_addr_o <= {req_addr_i[31:2], 2'b00};
          wmask      <= wmask_dec;
          if (req_we_i) mem_wdata_o <= wdata_dec;
        end
      end
      if (state == ISSUE)
        wait_cnt <= 2'(MEM_LATENCY - 1);
      else if (state == WAIT && wait_cnt != 2'd0)
        wait_cnt <= wait_cnt - 2'd1;
      if (state == WAIT && wait_cnt == 2'd0)
        rsp_rdata_o <= load_ext;
    end
  end

endmodule
